// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encoding and fixed
// instruction/address constants.
package mips_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_HOLD  = 2'd2;
    localparam fetch_state_t ST_DRAIN = 2'd3;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A bubble overrides a load and keeps the old PC+4.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc_plus_4_d,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus_4,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= NOP_INSTR;
            pc_plus_4   <= 32'h0000_0000;
            valid       <= 1'b0;
        end else if (bubble) begin
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
        end else if (load) begin
            instruction <= instr_d;
            pc_plus_4   <= pc_plus_4_d;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC, single-outstanding imem port, skid buffer for stalls
// and a pending-target register for redirects that arrive mid-request.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_addr,
    input  logic        Jump,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic [31:0] Imem_rdata,
    input  logic        Imem_ready,
    output logic [31:0] Instruction,
    output logic [31:0] PC_plus_4,
    output logic        IF_ID_Valid
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, pc_inc;
    logic [31:0]  skid_instr_q, skid_instr_d, skid_pc4_q, skid_pc4_d;
    logic [31:0]  pend_q, pend_d;
    logic         redirect;
    logic [31:0]  target;
    logic         ifid_load, ifid_bubble;
    logic [31:0]  ifid_instr, ifid_pc4;

    assign pc_inc    = pc_q + 32'd4;
    assign redirect  = (Jump | Branch_taken) & ~Stall;
    assign target    = Jump ? {PC_plus_4[31:28], Instruction[25:0], 2'b00} : Branch_addr;
    assign Imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign Imem_addr = pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        pend_d       = pend_q;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_instr   = Imem_rdata;
        ifid_pc4     = pc_inc;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                pc_d    = RESET_PC;
            end
            ST_FETCH: begin
                if (redirect) begin
                    ifid_bubble = 1'b1;
                    if (Imem_ready) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = ST_DRAIN;
                    end
                end else if (Imem_ready) begin
                    pc_d = pc_inc;
                    // A word returned under stall is parked so it is not refetched.
                    if (Stall) begin
                        skid_instr_d = Imem_rdata;
                        skid_pc4_d   = pc_inc;
                        state_d      = ST_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end else if (!Stall) begin
                    ifid_bubble = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!Stall) begin
                    state_d = ST_FETCH;
                    if (redirect) begin
                        pc_d        = target;
                        ifid_bubble = 1'b1;
                    end else begin
                        ifid_load  = 1'b1;
                        ifid_instr = skid_instr_q;
                        ifid_pc4   = skid_pc4_q;
                    end
                end
            end
            ST_DRAIN: begin
                // The old request must complete before the pending target is issued.
                ifid_bubble = ~Stall;
                if (Imem_ready) begin
                    pc_d    = pend_q;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            skid_instr_q <= 32'h0000_0000;
            skid_pc4_q   <= 32'h0000_0000;
            pend_q       <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            pend_q       <= pend_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (Clk),
        .rst_n       (Rst_n),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .instr_d     (ifid_instr),
        .pc_plus_4_d (ifid_pc4),
        .instruction (Instruction),
        .pc_plus_4   (PC_plus_4),
        .valid       (IF_ID_Valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic checked
// against a queue-based model of the fetch stage.
module tb_instruction_fetch;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        Stall = 1'b0;
    logic        Branch_taken = 1'b0;
    logic [31:0] Branch_addr = 32'h0;
    logic        Jump = 1'b0;
    logic        Imem_ready = 1'b0;
    logic [31:0] Imem_rdata = 32'h0;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic [31:0] Instruction;
    logic [31:0] PC_plus_4;
    logic        IF_ID_Valid;

    int n_checks = 0;
    int n_fails  = 0;
    bit scramble = 1'b0;

    // Reference model: pending redirects and skidded words live in queues.
    bit          m_started;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic [31:0] m_pending[$];
    logic [63:0] m_skid[$];

    wire [97:0] obs_vec = {Imem_req, Imem_addr, Instruction, PC_plus_4, IF_ID_Valid};

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Stall        (Stall),
        .Branch_taken (Branch_taken),
        .Branch_addr  (Branch_addr),
        .Jump         (Jump),
        .Imem_req     (Imem_req),
        .Imem_addr    (Imem_addr),
        .Imem_rdata   (Imem_rdata),
        .Imem_ready   (Imem_ready),
        .Instruction  (Instruction),
        .PC_plus_4    (PC_plus_4),
        .IF_ID_Valid  (IF_ID_Valid)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1000_0004) return 32'h0800_0040;
        if (scramble) return a ^ {a[15:0], 16'h0} ^ 32'h5A5A_0000;
        return a;
    endfunction

    function automatic logic [97:0] exp_vec();
        return {(m_started && (m_skid.size() == 0)), m_pc, m_instr, m_pc4, m_valid};
    endfunction

    function automatic void model_reset();
        m_started = 1'b0;
        m_pc      = RST_PC;
        m_instr   = 32'h0;
        m_pc4     = 32'h0;
        m_valid   = 1'b0;
        m_pending.delete();
        m_skid.delete();
    endfunction

    function automatic void model_bubble();
        m_instr = NOP_INSTR;
        m_valid = 1'b0;
    endfunction

    function automatic void model_edge(input bit stall, input bit br, input logic [31:0] baddr,
                                       input bit jmp, input bit ready, input logic [31:0] rdata);
        bit          redir;
        logic [31:0] tgt;
        logic [63:0] w;
        redir = (jmp || br) && !stall;
        tgt   = jmp ? {m_pc4[31:28], m_instr[25:0], 2'b00} : baddr;
        if (!m_started) begin
            m_started = 1'b1;
            m_pc      = RST_PC;
        end else if (m_pending.size() != 0) begin
            if (!stall) model_bubble();
            if (ready) m_pc = m_pending.pop_front();
        end else if (m_skid.size() != 0) begin
            if (!stall) begin
                w = m_skid.pop_front();
                if (redir) begin
                    m_pc = tgt;
                    model_bubble();
                end else begin
                    m_instr = w[63:32];
                    m_pc4   = w[31:0];
                    m_valid = 1'b1;
                end
            end
        end else if (redir) begin
            model_bubble();
            if (ready) m_pc = tgt;
            else m_pending.push_back(tgt);
        end else if (ready) begin
            if (stall) begin
                m_skid.push_back({rdata, m_pc + 32'd4});
            end else begin
                m_instr = rdata;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            model_bubble();
        end
    endfunction

    task automatic step(input bit stall, input bit br, input logic [31:0] baddr,
                        input bit jmp, input bit ready);
        Stall        = stall;
        Branch_taken = br;
        Branch_addr  = baddr;
        Jump         = jmp;
        Imem_ready   = ready;
        Imem_rdata   = ready ? mem_word(Imem_addr) : $urandom();
        @(posedge Clk);
        model_edge(stall, br, baddr, jmp, ready, Imem_rdata);
        #1;
    endtask

    task automatic test_reset();
        #2 Rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec !== {1'b0, RST_PC, 32'h0, 32'h0, 1'b0}) begin
            n_fails++;
            $display("[TB] FAIL reset actual=%h expected=%h", obs_vec, {1'b0, RST_PC, 32'h0, 32'h0, 1'b0});
        end
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fails++;
                $display("[TB] FAIL seq_model_%0d actual=%h expected=%h", k, obs_vec, exp_vec());
            end
            n_checks++;
            if (Imem_addr !== 32'(4 * (k - 1))) begin
                n_fails++;
                $display("[TB] FAIL seq_addr_%0d actual=%h expected=%h", k, Imem_addr, 32'(4 * (k - 1)));
            end
            if (k >= 2) begin
                n_checks++;
                if ({IF_ID_Valid, PC_plus_4} !== {1'b1, 32'(4 * (k - 1))}) begin
                    n_fails++;
                    $display("[TB] FAIL seq_ifid_%0d actual=%b/%h expected=1/%h", k, IF_ID_Valid, PC_plus_4, 32'(4 * (k - 1)));
                end
            end
        end
    endtask

    task automatic test_stall_hold();
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            n_checks++;
            if ({Imem_req, Instruction, IF_ID_Valid} !== {1'b0, 32'h0C, 1'b1}) begin
                n_fails++;
                $display("[TB] FAIL stall_hold_%0d actual=%b/%h/%b expected=0/0000000c/1", k, Imem_req, Instruction, IF_ID_Valid);
            end
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if ({Imem_req, Imem_addr, Instruction, PC_plus_4} !== {1'b1, 32'h14, 32'h10, 32'h14}) begin
            n_fails++;
            $display("[TB] FAIL stall_release actual=%h expected=%h", obs_vec, {1'b1, 32'h14, 32'h10, 32'h14, 1'b1});
        end
        n_checks++;
        if (obs_vec !== exp_vec()) begin
            n_fails++;
            $display("[TB] FAIL stall_model actual=%h expected=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_branch();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if ({Imem_addr, Instruction} !== {32'h20, 32'h1C}) begin
            n_fails++;
            $display("[TB] FAIL branch_setup actual=%h/%h expected=00000020/0000001c", Imem_addr, Instruction);
        end
        step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
        n_checks++;
        if (obs_vec !== {1'b1, 32'h100, 32'h0, 32'h20, 1'b0}) begin
            n_fails++;
            $display("[TB] FAIL branch_bubble actual=%h expected=%h", obs_vec, {1'b1, 32'h100, 32'h0, 32'h20, 1'b0});
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (obs_vec !== {1'b1, 32'h104, 32'h100, 32'h104, 1'b1}) begin
            n_fails++;
            $display("[TB] FAIL branch_target actual=%h expected=%h", obs_vec, {1'b1, 32'h104, 32'h100, 32'h104, 1'b1});
        end
    endtask

    task automatic test_jump_drain();
        step(1'b0, 1'b1, 32'h1000_0004, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if ({Instruction, PC_plus_4} !== {32'h0800_0040, 32'h1000_0008}) begin
            n_fails++;
            $display("[TB] FAIL jump_setup actual=%h/%h expected=08000040/10000008", Instruction, PC_plus_4);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({Imem_req, Imem_addr, IF_ID_Valid} !== {1'b1, 32'h1000_0008, 1'b0}) begin
                n_fails++;
                $display("[TB] FAIL jump_drain_%0d actual=%b/%h/%b expected=1/10000008/0", k, Imem_req, Imem_addr, IF_ID_Valid);
            end
            step(1'b0, 1'b0, 32'h0, 1'b0, (k == 2));
        end
        n_checks++;
        if ({Imem_req, Imem_addr} !== {1'b1, 32'h1000_0100}) begin
            n_fails++;
            $display("[TB] FAIL jump_target actual=%b/%h expected=1/10000100", Imem_req, Imem_addr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (obs_vec !== exp_vec()) begin
            n_fails++;
            $display("[TB] FAIL jump_model actual=%h expected=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_stall_masks();
        step(1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
        n_checks++;
        if (obs_vec !== {1'b1, 32'h1000_0104, 32'h1000_0100, 32'h1000_0104, 1'b1}) begin
            n_fails++;
            $display("[TB] FAIL mask_idle actual=%h expected=%h", obs_vec, {1'b1, 32'h1000_0104, 32'h1000_0100, 32'h1000_0104, 1'b1});
        end
        step(1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
        n_checks++;
        if ({Imem_req, Imem_addr, Instruction} !== {1'b0, 32'h1000_0108, 32'h1000_0100}) begin
            n_fails++;
            $display("[TB] FAIL mask_ready actual=%b/%h/%h expected=0/10000108/10000100", Imem_req, Imem_addr, Instruction);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (obs_vec !== exp_vec()) begin
            n_fails++;
            $display("[TB] FAIL mask_model actual=%h expected=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mid_drain();
        step(1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if ({Imem_req, Imem_addr} !== exp_vec()[97:65]) begin
            n_fails++;
            $display("[TB] FAIL drain_pre actual=%b/%h expected=%h", Imem_req, Imem_addr, exp_vec()[97:65]);
        end
        #1 Rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec !== {1'b0, RST_PC, 32'h0, 32'h0, 1'b0}) begin
            n_fails++;
            $display("[TB] FAIL drain_reset actual=%h expected=%h", obs_vec, {1'b0, RST_PC, 32'h0, 32'h0, 1'b0});
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if ({Imem_req, Imem_addr, IF_ID_Valid} !== {1'b1, RST_PC, 1'b0}) begin
            n_fails++;
            $display("[TB] FAIL drain_restart actual=%b/%h/%b expected=1/%h/0", Imem_req, Imem_addr, IF_ID_Valid, RST_PC);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (obs_vec !== exp_vec()) begin
            n_fails++;
            $display("[TB] FAIL drain_refetch actual=%h expected=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        bit          st, br, jp, rd;
        logic [31:0] ba;
        scramble = 1'b1;
        for (int k = 0; k < 600; k++) begin
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 9) < 6);
            br = m_valid && ($urandom_range(0, 7) == 0);
            jp = m_valid && ($urandom_range(0, 9) == 0);
            ba = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            step(st, br, ba, jp, rd);
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fails++;
                $display("[TB] FAIL random_%0d actual=%h expected=%h", k, obs_vec, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_stall_hold();
        test_branch();
        test_jump_drain();
        test_stall_masks();
        test_reset_mid_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
